// File: rtl/npc_pkg.sv
// Shared types and defaults for the NPC multi-cycle sequencer.
package npc_pkg;

  localparam int          NPC_XLEN     = 64;
  localparam logic [63:0] NPC_RESET_PC = 64'h8000_0000;
  localparam int          NPC_TIMEOUT  = 255;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } npc_state_t;

  // Counter width able to hold TIMEOUT; at least one bit so TIMEOUT=0 still elaborates.
  function automatic int wait_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/npc_wait_timer.sv
// Saturating wait counter shared by the fetch and load/store handshakes.
module npc_wait_timer
  import npc_pkg::*;
#(
  parameter int TIMEOUT = NPC_TIMEOUT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = wait_cnt_w(TIMEOUT);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      cnt_reg <= '0;
    end else if (en && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  // expired flags the last allowed wait cycle; the FSM traps on the following edge.
  generate
    if (TIMEOUT == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      assign expired = (cnt_reg == W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/npc_seq_ctrl.sv
// NPC core sequencer: FETCH -> DECODE -> EXEC -> [MEM] -> WB, with sticky halt/trap stops.
module npc_seq_ctrl
  import npc_pkg::*;
#(
  parameter int              XLEN     = NPC_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(NPC_RESET_PC),
  parameter int              TIMEOUT  = NPC_TIMEOUT
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            if_req,
  output logic [XLEN-1:0] if_addr,
  input  logic            if_ack,
  input  logic [31:0]     if_inst,
  output logic [31:0]     inst_o,
  output logic            dec_en,
  input  logic            dec_ldst,
  input  logic            dec_rd_we,
  input  logic            dec_ebreak,
  input  logic            dec_illegal,
  output logic            ex_en,
  input  logic [XLEN-1:0] next_pc,
  output logic            ls_req,
  input  logic            ls_ack,
  output logic            rf_we,
  output logic [XLEN-1:0] pc_o,
  output logic            halt,
  output logic            trap
);

  npc_state_t      state_reg, state_next;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] npc_reg;
  logic [31:0]     inst_reg;
  logic            ldst_reg;
  logic            rd_we_reg;
  logic            halt_reg;
  logic            trap_reg;
  logic            tmr_en;
  logic            tmr_expired;

  npc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (!tmr_en),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // The timer only runs on cycles spent waiting for an ack; anything else clears it.
  always_comb begin
    state_next = state_reg;
    tmr_en     = 1'b0;
    case (state_reg)
      S_FETCH: begin
        if (if_ack) begin
          state_next = S_DECODE;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) state_next = S_TRAP;
        end
      end
      S_DECODE: begin
        if (dec_illegal)     state_next = S_TRAP;
        else if (dec_ebreak) state_next = S_HALT;
        else                 state_next = S_EXEC;
      end
      S_EXEC:  state_next = ldst_reg ? S_MEM : S_WB;
      S_MEM: begin
        if (ls_ack) begin
          state_next = S_WB;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) state_next = S_TRAP;
        end
      end
      S_WB:    state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= S_FETCH;
      pc_reg    <= RESET_PC;
      npc_reg   <= RESET_PC;
      inst_reg  <= '0;
      ldst_reg  <= 1'b0;
      rd_we_reg <= 1'b0;
      halt_reg  <= 1'b0;
      trap_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_FETCH && if_ack) inst_reg <= if_inst;
      if (state_reg == S_DECODE) begin
        ldst_reg  <= dec_ldst;
        rd_we_reg <= dec_rd_we;
      end
      if (state_reg == S_EXEC) npc_reg <= next_pc;
      if (state_reg == S_WB)   pc_reg  <= npc_reg;
      if (state_next == S_HALT) halt_reg <= 1'b1;
      if (state_next == S_TRAP) trap_reg <= 1'b1;
    end
  end

  // Requests and enables decode straight from the state register, so they are glitch-free
  // and a request cannot drop before its ack has moved the FSM on.
  assign if_req  = (state_reg == S_FETCH);
  assign ls_req  = (state_reg == S_MEM);
  assign dec_en  = (state_reg == S_DECODE);
  assign ex_en   = (state_reg == S_EXEC);
  assign rf_we   = (state_reg == S_WB) && rd_we_reg;
  assign if_addr = pc_reg;
  assign pc_o    = pc_reg;
  assign inst_o  = inst_reg;
  assign halt    = halt_reg;
  assign trap    = trap_reg;

endmodule
